// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the MEM-stage data cache.
// The controller and array import these.
package dcache_pkg;

    localparam int DC_INDEX_BITS = 5;
    localparam int DC_LINE_WORDS = 4;
    localparam int OB            = 2 + $clog2(DC_LINE_WORDS);
    localparam int TAG_BITS      = 32 - OB - DC_INDEX_BITS;
    localparam int LINE_BITS     = 32 * DC_LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// It has one write port (line refill or single word) and a combinational read on the index.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DC_INDEX_BITS,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    parameter int TAG_W      = TAG_BITS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [INDEX_BITS-1:0]         rd_idx,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [32*LINE_WORDS-1:0]      rd_line,
    input  logic [INDEX_BITS-1:0]         wr_idx,
    input  logic                          line_we,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic [32*LINE_WORDS-1:0]      wr_line,
    input  logic                          word_we,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
    input  logic [31:0]                   wr_word
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]               valid_q;
    logic [TAG_W-1:0]               tag_q  [LINES];
    logic [LINE_WORDS-1:0][31:0]    data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end else if (word_we) begin
            data_q[wr_idx][wr_off] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, write-through, read-allocate.
// It drives the pipeline hold and the single-request memory interface.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DC_INDEX_BITS,
    parameter int LINE_WORDS = DC_LINE_WORDS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     MemRead_i,
    input  logic                     MemWrite_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     hold_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i
);

    localparam int OFS_BITS = $clog2(LINE_WORDS);
    localparam int IDX_LSB  = 2 + OFS_BITS;
    localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;
    localparam int TAG_W    = 32 - TAG_LSB;
    localparam logic [31:0] LINE_MASK = ~((32'(LINE_WORDS) << 2) - 32'd1);
    localparam logic [31:0] WORD_MASK = ~32'd3;

    dc_state_e                   state_q;
    logic [INDEX_BITS-1:0]       idx;
    logic [TAG_W-1:0]            tag;
    logic [OFS_BITS-1:0]         off;
    logic                        rd_valid;
    logic [TAG_W-1:0]            rd_tag;
    logic [32*LINE_WORDS-1:0]    rd_line;
    logic [LINE_WORDS-1:0][31:0] line_words;
    logic                        hit;
    logic                        hold_c;

    assign idx        = addr_i[TAG_LSB-1:IDX_LSB];
    assign tag        = addr_i[31:TAG_LSB];
    assign off        = addr_i[IDX_LSB-1:2];
    assign line_words = rd_line;
    assign hit        = rd_valid && (rd_tag == tag);

    // Inputs are frozen while holding, so addr_i still names the outstanding access.
    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_idx   (idx),
        .line_we  ((state_q == ST_RD_MISS) && mem_ack_i),
        .wr_tag   (tag),
        .wr_line  (mem_rdata_i),
        .word_we  ((state_q == ST_WR_THRU) && mem_ack_i && hit),
        .wr_off   (off),
        .wr_word  (wdata_i)
    );

    always_comb begin
        hold_c = 1'b0;
        case (state_q)
            ST_IDLE:    hold_c = MemWrite_i || (MemRead_i && !hit);
            ST_RD_MISS: hold_c = 1'b1;
            ST_WR_THRU: hold_c = !mem_ack_i;
            default:    hold_c = 1'b0;
        endcase
    end

    // While reset is asserted, hold and load data are forced low even though the inputs may still request an access.
    assign hold_o  = rst_i && hold_c;
    assign rdata_o = rst_i ? line_words[off] : 32'd0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MemWrite_i) begin
                        state_q     <= ST_WR_THRU;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr_i & WORD_MASK;
                        mem_wdata_o <= wdata_i;
                    end else if (MemRead_i && !hit) begin
                        state_q    <= ST_RD_MISS;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= addr_i & LINE_MASK;
                    end
                end
                ST_RD_MISS, ST_WR_THRU: begin
                    if (mem_ack_i) begin
                        state_q   <= ST_IDLE;
                        mem_req_o <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: scripted scenarios plus randomized traffic.
// A transaction-level model tracks memory contents and which lines are resident.
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         hold_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_ack_i;
    logic [127:0] mem_rdata_i;

    dcache_ctrl #(.INDEX_BITS(5), .LINE_WORDS(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .hold_o      (hold_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference memory contents; every load must return these because the cache is write-through.
    logic [31:0] mem [int unsigned];
    // Which tag each index currently holds.
    bit          res_v   [32];
    logic [22:0] res_tag [32];

    logic [31:0] last_rdata;
    int          last_holds;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        if (mem.exists(w)) return mem[w];
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One pipeline access. The task is entered just after a rising edge and returns just after the rising edge on which the access retires.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat);
        int          idx;
        logic [22:0] tg;
        bit          miss;
        bit          uses_mem;
        int          exp_hold;
        logic [31:0] exp_maddr;
        logic [31:0] base;
        logic [127:0] ln;
        idx       = int'(a[8:4]);
        tg        = a[31:9];
        miss      = rd && !wr && !(res_v[idx] && res_tag[idx] == tg);
        uses_mem  = wr || miss;
        exp_hold  = wr ? lat : (miss ? lat + 1 : 0);
        exp_maddr = wr ? (a & ~32'd3) : (a & ~32'd15);
        base      = a & ~32'd15;
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        last_holds = 0;
        for (int c = 0; c <= exp_hold; c++) begin
            mem_ack_i = uses_mem && (c == lat);
            if (mem_ack_i && !wr) begin
                for (int k = 0; k < 4; k++) ln[k*32 +: 32] = mem_rd(base + 32'(4*k));
                mem_rdata_i = ln;
            end
            @(negedge clk_i);
            if (hold_o) last_holds++;
            chk("hold", {31'd0, hold_o}, {31'd0, c < exp_hold});
            chk("mem_req", {31'd0, mem_req_o}, {31'd0, uses_mem && c >= 1 && c <= lat});
            if (uses_mem && c >= 1 && c <= lat) begin
                chk("mem_we", {31'd0, mem_we_o}, {31'd0, wr});
                chk("mem_addr", mem_addr_o, exp_maddr);
                if (wr) chk("mem_wdata", mem_wdata_o, wd);
            end
            if (c == exp_hold && rd && !wr) chk("rdata", rdata_o, mem_rd(a));
            last_rdata = rdata_o;
            if (mem_ack_i) begin
                if (wr) mem[a & ~32'd3] = wd;
                else begin
                    res_v[idx]   = 1'b1;
                    res_tag[idx] = tg;
                end
            end
            @(posedge clk_i);
            #1;
        end
        mem_ack_i  = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b0;
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        addr_i      = 32'h40;
        wdata_i     = 32'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        for (int i = 0; i < 32; i++) res_v[i] = 1'b0;
        mem[32'h40] = 32'd1;
        mem[32'h44] = 32'd2;
        mem[32'h48] = 32'd3;
        mem[32'h4C] = 32'd4;

        // Reset state: outputs are low even with a load presented.
        #12;
        chk("rst_hold", {31'd0, hold_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        MemRead_i = 1'b0;
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: cold miss on the line {4,3,2,1}, then a hit on the next word.
        run_op(1, 0, 32'h40, 0, 3);
        chk("t1_holds", 32'(last_holds), 32'd4);
        chk("t1_rdata", last_rdata, 32'd1);
        run_op(1, 0, 32'h44, 0, 3);
        chk("t1_hit_holds", 32'(last_holds), 32'd0);
        chk("t1_hit_rdata", last_rdata, 32'd2);

        // 2: write hit goes through to memory and updates the cached word.
        run_op(0, 1, 32'h48, 32'hDEAD_BEEF, 2);
        chk("t2_holds", 32'(last_holds), 32'd2);
        run_op(1, 0, 32'h48, 0, 2);
        chk("t2_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("t2_hit_holds", 32'(last_holds), 32'd0);

        // 3: write miss does not allocate.
        run_op(0, 1, 32'h1000, 32'h1234_5678, 2);
        run_op(1, 0, 32'h1000, 0, 2);
        chk("t3_holds", 32'(last_holds), 32'd3);
        chk("t3_rdata", last_rdata, 32'h1234_5678);

        // 4: conflict eviction on index 4.
        run_op(1, 0, 32'h40, 0, 2);
        chk("t4_hit_holds", 32'(last_holds), 32'd0);
        run_op(1, 0, 32'h840, 0, 2);
        chk("t4_evict_holds", 32'(last_holds), 32'd3);
        run_op(1, 0, 32'h40, 0, 4);
        chk("t4_remiss_holds", 32'(last_holds), 32'd5);
        chk("t4_rdata", last_rdata, 32'd1);

        // 5: reset during a refill, then a stray ack arrives in IDLE.
        MemRead_i = 1'b1;
        addr_i    = 32'h2040;
        @(negedge clk_i);
        chk("t5_hold_pre", {31'd0, hold_o}, 32'd1);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("t5_req_pre", {31'd0, mem_req_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("t5_req_rst", {31'd0, mem_req_o}, 32'd0);
        chk("t5_hold_rst", {31'd0, hold_o}, 32'd0);
        for (int i = 0; i < 32; i++) res_v[i] = 1'b0;
        MemRead_i = 1'b0;
        addr_i    = 32'h40;
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = {4{32'hBAD0_BAD0}};
        @(negedge clk_i);
        chk("t5_stray_req", {31'd0, mem_req_o}, 32'd0);
        chk("t5_stray_hold", {31'd0, hold_o}, 32'd0);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("t5_after_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        run_op(1, 0, 32'h40, 0, 2);
        chk("t5_miss_holds", 32'(last_holds), 32'd3);
        chk("t5_rdata", last_rdata, 32'd1);

        // 6: back-to-back hits, then a read+write combination takes the write path.
        run_op(1, 0, 32'h40, 0, 2);
        chk("t6_a_rdata", last_rdata, 32'd1);
        run_op(1, 0, 32'h44, 0, 2);
        chk("t6_b_rdata", last_rdata, 32'd2);
        run_op(1, 0, 32'h48, 0, 2);
        chk("t6_c_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("t6_c_holds", 32'(last_holds), 32'd0);
        run_op(1, 1, 32'h4C, 32'h0000_0055, 3);
        chk("t6_rw_holds", 32'(last_holds), 32'd3);
        run_op(1, 0, 32'h4C, 0, 2);
        chk("t6_rw_rdata", last_rdata, 32'h0000_0055);

        // Randomized traffic over a small address pool so hits, conflicts and write hits all occur.
        for (int n = 0; n < 250; n++) begin
            int          kind;
            logic [31:0] a;
            a = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            if (kind <= 4)      run_op(1, 0, a, 32'd0, $urandom_range(2, 5));
            else if (kind <= 7) run_op(0, 1, a, $urandom, $urandom_range(2, 5));
            else if (kind == 8) run_op(1, 1, a, $urandom, $urandom_range(2, 5));
            else                run_op(0, 0, a, 32'd0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
